// File: rtl/eeprom_pkg.sv
// Shared types and constants for the two-wire serial EEPROM slave.
// Contents:
//   CTRL_CODE      fixed device-type code expected in control byte [7:4]
//   BYTE_W, CNT_W  byte width and bit-counter width
//   eeprom_state_t protocol FSM state encoding
package eeprom_pkg;

    localparam logic [3:0]  CTRL_CODE = 4'b1010;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [3:0] {
        StIdle,
        StCtrl,
        StAckCtrl,
        StAddrHi,
        StAckHi,
        StAddrLo,
        StAckLo,
        StWrite,
        StAckWr,
        StRead,
        StMack,
        StWaitStop
    } eeprom_state_t;

endpackage

// File: rtl/eeprom_bus_monitor.sv
// Two-wire bus monitor: registers scl/sda once and derives single-cycle event pulses.
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   scl_i, sda_i           raw bus lines (already synchronous to clk_i)
//   sda_o                  registered sda
//   scl_rise_o/scl_fall_o  one-cycle scl edge pulses
//   start_o/stop_o         one-cycle START / STOP condition pulses
module eeprom_bus_monitor (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_q, sda_q, scl_prev_q, sda_prev_q;

    // Reset to the idle-bus level so leaving reset creates no false START/STOP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_q      <= scl_i;
            sda_q      <= sda_i;
            scl_prev_q <= scl_q;
            sda_prev_q <= sda_q;
        end
    end

    assign sda_o      = sda_q;
    assign scl_rise_o = scl_q & ~scl_prev_q;
    assign scl_fall_o = ~scl_q & scl_prev_q;
    // Only the current scl level is required, so an sda edge coinciding with an
    // scl rise still counts as START/STOP; the FSM gives these priority.
    assign start_o    = scl_q & sda_prev_q & ~sda_q;
    assign stop_o     = scl_q & ~sda_prev_q & sda_q;

endmodule

// File: rtl/eeprom_i2c_slave.sv
// Two-wire serial EEPROM slave (24Cxx-style) with an external single-port byte array.
// Supports control byte, 2-byte word address, page write, current/random/sequential read.
// Optional build macro EEPROM_WP_EN adds input wp: when high, data bytes are NACKed and
// never written (address bytes are still ACKed).
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   scl, sda_in, sda_out  serial bus (sda_out: 1 = release, 0 = pull low)
//   mem_addr/wdata/we/re  byte-array request; mem_rdata valid the clk after mem_re
//   busy                  transfer in progress (START until STOP)
module eeprom_i2c_slave
    import eeprom_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned PAGE_BITS  = 5,
    parameter logic [2:0]  DEV_SEL    = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    input  logic                  sda_in,
`ifdef EEPROM_WP_EN
    input  logic                  wp,
`endif
    output logic                  sda_out,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BYTE_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [BYTE_W-1:0]     mem_rdata,
    output logic                  busy
);

    logic sda, scl_rise, scl_fall, start, stop, wp_active;

    eeprom_bus_monitor u_bus_monitor (
        .clk_i      (clk),
        .rst_ni     (reset),
        .scl_i      (scl),
        .sda_i      (sda_in),
        .sda_o      (sda),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

`ifdef EEPROM_WP_EN
    assign wp_active = wp;
`else
    assign wp_active = 1'b0;
`endif

    eeprom_state_t         state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]     shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  sda_out_q, sda_out_d, ack_q, ack_d, rw_q, rw_d;
    logic                  mem_we_q, mem_we_d, mem_re_q, mem_re_d, rd_pend_q;

    logic [BYTE_W-1:0]     rx_byte;
    logic [PAGE_BITS-1:0]  page_lo;
    assign rx_byte = {shift_q[BYTE_W-2:0], sda};
    assign page_lo = ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            sda_out_q   <= 1'b1;
            ack_q       <= 1'b0;
            rw_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            sda_out_q   <= sda_out_d;
            ack_q       <= ack_d;
            rw_q        <= rw_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            rd_pend_q   <= mem_re_q;
        end
    end

    // bit_cnt: 0..8 bits of the current byte; in ACK states 8 = waiting for the fall
    // that starts the ACK slot, 9 = ACK slot driven, waiting for the fall that ends it.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sda_out_d   = sda_out_q;
        ack_d       = ack_q;
        rw_d        = rw_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;

        if (start) begin
            state_d   = StCtrl;
            bit_cnt_d = '0;
            sda_out_d = 1'b1;
        end else if (stop) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            sda_out_d = 1'b1;
        end else begin
            if (rd_pend_q) shift_d = mem_rdata;
            unique case (state_q)
                StCtrl, StAddrHi, StAddrLo, StWrite: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            ack_d = 1'b1;
                            case (state_q)
                                StCtrl: begin
                                    if (rx_byte[7:4] != CTRL_CODE || rx_byte[3:1] != DEV_SEL) begin
                                        state_d = StWaitStop;
                                    end else begin
                                        rw_d    = rx_byte[0];
                                        state_d = StAckCtrl;
                                    end
                                end
                                StAddrHi: begin
                                    ptr_d[ADDR_WIDTH-1:8] = rx_byte[ADDR_WIDTH-9:0];
                                    state_d = StAckHi;
                                end
                                StAddrLo: begin
                                    ptr_d[7:0] = rx_byte;
                                    state_d    = StAckLo;
                                end
                                default: begin
                                    state_d = StAckWr;
                                    if (wp_active) begin
                                        ack_d = 1'b0;
                                    end else begin
                                        mem_we_d    = 1'b1;
                                        mem_addr_d  = ptr_q;
                                        mem_wdata_d = rx_byte;
                                        ptr_d       = {ptr_q[ADDR_WIDTH-1:PAGE_BITS], page_lo};
                                    end
                                end
                            endcase
                        end
                    end
                end
                StAckCtrl, StAckHi, StAckLo, StAckWr: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == CNT_W'(8)) begin
                            sda_out_d = ~ack_q;
                            bit_cnt_d = CNT_W'(9);
                            if (state_q == StAckCtrl && rw_q) begin
                                mem_re_d   = 1'b1;
                                mem_addr_d = ptr_q;
                            end
                        end else begin
                            sda_out_d = 1'b1;
                            bit_cnt_d = '0;
                            case (state_q)
                                StAckCtrl: begin
                                    if (rw_q) begin
                                        // First read bit goes out on the fall ending the ACK.
                                        state_d   = StRead;
                                        sda_out_d = shift_q[7];
                                        shift_d   = {shift_q[6:0], 1'b0};
                                        bit_cnt_d = CNT_W'(1);
                                    end else begin
                                        state_d = StAddrHi;
                                    end
                                end
                                StAckHi: state_d = StAddrLo;
                                default: state_d = StWrite;
                            endcase
                        end
                    end
                end
                StRead: begin
                    if (scl_fall) begin
                        if (bit_cnt_q < CNT_W'(8)) begin
                            sda_out_d = shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end else begin
                            sda_out_d = 1'b1;
                            state_d   = StMack;
                        end
                    end
                end
                StMack: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            ptr_d      = ptr_q + ADDR_WIDTH'(1);
                            mem_re_d   = 1'b1;
                            mem_addr_d = ptr_q + ADDR_WIDTH'(1);
                            bit_cnt_d  = '0;
                            state_d    = StRead;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end
                end
                StIdle, StWaitStop: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign sda_out   = sda_out_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = (state_q != StIdle);

endmodule
